// File: rtl/ring_pkg.sv
// Shared types and default sizing for the ring station egress and ingress logic.
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        LOCAL
    } tx_state_e;

    localparam int DEF_PKT_LEN = 4;
    localparam int DEF_CREDITS = 2;

endpackage

// File: rtl/ring_credit_cnt.sv
// Credit counter mirroring a downstream buffer of CREDITS entries.
// The same block tracks credits on the station ingress side.
module ring_credit_cnt
    import ring_pkg::*;
#(
    parameter int CREDITS = DEF_CREDITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iSend,
    input  logic                           iRet,
    output logic [$clog2(CREDITS+1)-1:0]   oCnt,
    output logic                           oAvail
);

    localparam int            CW   = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // A send and a return in the same cycle cancel; a return while full saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            oCnt <= FULL;
        end else if (iSend && !iRet) begin
            oCnt <= oCnt - ONE;
        end else if (iRet && !iSend && oCnt != FULL) begin
            oCnt <= oCnt + ONE;
        end
    end

    assign oAvail = (oCnt != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            creditOverflow: assert (!(iRet && oCnt == FULL));
        end
    end

endmodule

// File: rtl/ring_tx_port.sv
// Ring station egress: packet-granular arbitration between local inject and pass-through,
// credit-gated, one registered flit per cycle. Define RING_TX_PERF_EN to add perf counters.
module ring_tx_port
    import ring_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CREDITS    = DEF_CREDITS,
    parameter int PKT_LEN    = DEF_PKT_LEN,
    parameter int STARVE_MAX = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iLocEmpty,
    input  logic [WIDTH-1:0]               iLocDat,
    output logic                           oLocRdEn,
    input  logic                           iPassVld,
    input  logic [WIDTH-1:0]               iPassDat,
    output logic                           oPassRdy,
    input  logic                           iCreditRet,
    output logic                           oTxVld,
    output logic [WIDTH-1:0]               oTxDat,
    output logic                           oTxLast,
    output logic [$clog2(CREDITS+1)-1:0]   oCredits
`ifdef RING_TX_PERF_EN
    ,
    output logic [31:0]                    oPerfFlits,
    output logic [31:0]                    oPerfCredStall,
    output logic [31:0]                    oPerfStarve
`endif
);

    localparam int            BW         = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(PKT_LEN - 1);
    localparam logic [BW-1:0] BEAT_ONE   = BW'(1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    tx_state_e        state;
    tx_state_e        stateNext;
    logic [BW-1:0]    beat;
    logic [SW-1:0]    starveCnt;
    logic             activeLocal;
    logic             activePass;
    logic             hasData;
    logic             xfer;
    logic             lastBeat;
    logic             credAvail;
    logic [WIDTH-1:0] txDatNext;

    ring_credit_cnt #(
        .CREDITS (CREDITS)
    ) uCredit (
        .clk    (clk),
        .rst    (rst),
        .iSend  (xfer),
        .iRet   (iCreditRet),
        .oCnt   (oCredits),
        .oAvail (credAvail)
    );

    // The grant is only committed when beat 0 actually moves, so a credit-starved
    // IDLE cycle re-arbitrates on the next cycle instead of locking in a source.
    always_comb begin
        stateNext   = state;
        activeLocal = 1'b0;
        activePass  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!iLocEmpty && (!iPassVld || starveCnt == STARVE_TOP)) begin
                    activeLocal = 1'b1;
                end else if (iPassVld) begin
                    activePass = 1'b1;
                end
            end
            PASS:    activePass  = 1'b1;
            LOCAL:   activeLocal = 1'b1;
            default: stateNext   = IDLE;
        endcase

        hasData   = (activeLocal && !iLocEmpty) || (activePass && iPassVld);
        xfer      = credAvail && hasData;
        lastBeat  = (beat == LAST_BEAT);
        txDatNext = activeLocal ? iLocDat : iPassDat;

        if (xfer) begin
            if (lastBeat) begin
                stateNext = IDLE;
            end else if (state == IDLE) begin
                stateNext = activeLocal ? LOCAL : PASS;
            end
        end
    end

    assign oLocRdEn = xfer && activeLocal;
    assign oPassRdy = xfer && activePass;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            starveCnt <= '0;
            oTxVld    <= 1'b0;
            oTxDat    <= '0;
            oTxLast   <= 1'b0;
        end else begin
            state   <= stateNext;
            oTxVld  <= xfer;
            oTxLast <= xfer && lastBeat;
            if (xfer) begin
                oTxDat <= txDatNext;
                beat   <= lastBeat ? '0 : beat + BEAT_ONE;
            end
            if (xfer && state == IDLE) begin
                if (activeLocal) begin
                    starveCnt <= '0;
                end else if (!iLocEmpty && starveCnt != STARVE_TOP) begin
                    starveCnt <= starveCnt + STARVE_ONE;
                end
            end
        end
    end

`ifdef RING_TX_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            oPerfFlits     <= '0;
            oPerfCredStall <= '0;
            oPerfStarve    <= '0;
        end else begin
            if (xfer) begin
                oPerfFlits <= oPerfFlits + 32'd1;
            end
            if (hasData && !credAvail) begin
                oPerfCredStall <= oPerfCredStall + 32'd1;
            end
            if (state == IDLE && !iLocEmpty && activePass && xfer) begin
                oPerfStarve <= oPerfStarve + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ring_tx_port.sv
// Self-checking bench for ring_tx_port: grant table from IDLE plus scoreboarded packet sequences.
module tb_ring_tx_port;

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
    } flit_t;

    typedef struct {
        logic        locEmpty;
        logic        passVld;
        logic [31:0] locDat;
        logic [31:0] passDat;
        logic        expLocRd;
        logic        expPassRd;
        logic        expTxVld;
        logic [31:0] expTxDat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iLocEmpty = 1'b1;
    logic [31:0] iLocDat = '0;
    logic        oLocRdEn;
    logic        iPassVld = 1'b0;
    logic [31:0] iPassDat = '0;
    logic        oPassRdy;
    logic        iCreditRet = 1'b0;
    logic        oTxVld;
    logic [31:0] oTxDat;
    logic        oTxLast;
    logic [1:0]  oCredits;
`ifdef RING_TX_PERF_EN
    logic [31:0] perfFlits;
    logic [31:0] perfCredStall;
    logic [31:0] perfStarve;
`endif

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          vldCount = 0;
    int          firstVld = 0;
    int          lastVld = 0;
    int          locPulses = 0;
    int          lastCount = 0;
    bit          autoRet = 1'b0;
    logic [31:0] locQ[$];
    logic [31:0] passQ[$];
    flit_t       expQ[$];
    vec_t        vecs[5];

    ring_tx_port #(
        .WIDTH      (32),
        .CREDITS    (2),
        .PKT_LEN    (4),
        .STARVE_MAX (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iLocEmpty  (iLocEmpty),
        .iLocDat    (iLocDat),
        .oLocRdEn   (oLocRdEn),
        .iPassVld   (iPassVld),
        .iPassDat   (iPassDat),
        .oPassRdy   (oPassRdy),
        .iCreditRet (iCreditRet),
        .oTxVld     (oTxVld),
        .oTxDat     (oTxDat),
        .oTxLast    (oTxLast),
        .oCredits   (oCredits)
`ifdef RING_TX_PERF_EN
        ,
        .oPerfFlits     (perfFlits),
        .oPerfCredStall (perfCredStall),
        .oPerfStarve    (perfStarve)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic driveSrc();
        iLocEmpty = (locQ.size() == 0);
        iLocDat   = iLocEmpty ? 32'hDEAD_BEEF : locQ[0];
        iPassVld  = (passQ.size() != 0);
        iPassDat  = iPassVld ? passQ[0] : 32'hCAFE_F00D;
    endtask

    task automatic srcPkt(input logic [31:0] base, input bit toLocal);
        for (int i = 0; i < 4; i++) begin
            if (toLocal) locQ.push_back(base + 32'(i));
            else         passQ.push_back(base + 32'(i));
        end
    endtask

    task automatic expPkt(input logic [31:0] base);
        flit_t e;
        for (int i = 0; i < 4; i++) begin
            e.dat  = base + 32'(i);
            e.last = (i == 3);
            expQ.push_back(e);
        end
    endtask

    task automatic doReset();
        rst        = 1'b1;
        autoRet    = 1'b0;
        iCreditRet = 1'b0;
        locQ.delete();
        passQ.delete();
        expQ.delete();
        driveSrc();
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        vldCount  = 0;
        locPulses = 0;
        lastCount = 0;
    endtask

    // One clock: capture the combinational pops, advance the source models,
    // score the registered output and model the downstream credit return.
    task automatic step();
        flit_t e;
        bit    lp;
        bit    pp;
        #1;
        lp = oLocRdEn;
        pp = oPassRdy;
        checkOutput("rd_onehot", {63'b0, lp && pp}, 64'd0);
        @(posedge clk);
        #1;
        cycle++;
        if (lp) begin
            locPulses++;
            if (locQ.size() > 0) locQ.delete(0);
        end
        if (pp && passQ.size() > 0) passQ.delete(0);
        if (oTxVld) begin
            vldCount++;
            if (vldCount == 1) firstVld = cycle;
            lastVld = cycle;
            if (oTxLast) lastCount++;
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_spurious: actual flit %0h expected none", oTxDat);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_data", {32'b0, oTxDat}, {32'b0, e.dat});
                checkOutput("sb_last", {63'b0, oTxLast}, {63'b0, e.last});
            end
        end else begin
            checkOutput("last_without_vld", {63'b0, oTxLast}, 64'd0);
        end
        iCreditRet = autoRet && oTxVld;
        driveSrc();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (expQ.size() > 0 && n < budget) begin
            step();
            n++;
        end
        checkOutput("drain_left", 64'(expQ.size()), 64'd0);
        repeat (3) step();
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        doReset();
        iLocEmpty = v.locEmpty;
        iLocDat   = v.locDat;
        iPassVld  = v.passVld;
        iPassDat  = v.passDat;
        #1;
        checkOutput($sformatf("tbl%0d_locRdEn", idx), {63'b0, oLocRdEn}, {63'b0, v.expLocRd});
        checkOutput($sformatf("tbl%0d_passRdy", idx), {63'b0, oPassRdy}, {63'b0, v.expPassRd});
        @(posedge clk);
        #1;
        iLocEmpty = 1'b1;
        iPassVld  = 1'b0;
        checkOutput($sformatf("tbl%0d_txVld", idx), {63'b0, oTxVld}, {63'b0, v.expTxVld});
        checkOutput($sformatf("tbl%0d_txDat", idx), {32'b0, oTxDat}, {32'b0, v.expTxDat});
        checkOutput($sformatf("tbl%0d_txLast", idx), {63'b0, oTxLast}, 64'd0);
    endtask

    initial begin
        // locEmpty, passVld, locDat, passDat, expLocRd, expPassRd, expTxVld, expTxDat
        vecs[0] = '{1'b1, 1'b0, 32'h1111_0000, 32'h2222_0000, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'hAAAA_0001, 32'h2222_0001, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001};
        vecs[2] = '{1'b1, 1'b1, 32'h1111_0002, 32'hBBBB_0002, 1'b0, 1'b1, 1'b1, 32'hBBBB_0002};
        vecs[3] = '{1'b0, 1'b1, 32'hAAAA_0003, 32'hBBBB_0003, 1'b0, 1'b1, 1'b1, 32'hBBBB_0003};
        vecs[4] = '{1'b1, 1'b0, 32'h1111_0004, 32'h2222_0004, 1'b0, 1'b0, 1'b0, 32'h0};

        // Reset state with idle sources.
        doReset();
        checkOutput("rst_txVld", {63'b0, oTxVld}, 64'd0);
        checkOutput("rst_txLast", {63'b0, oTxLast}, 64'd0);
        checkOutput("rst_credits", {62'b0, oCredits}, 64'd2);
        #1;
        checkOutput("rst_locRdEn", {63'b0, oLocRdEn}, 64'd0);
        checkOutput("rst_passRdy", {63'b0, oPassRdy}, 64'd0);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        // Local packet, credits returned one cycle after each flit.
        doReset();
        autoRet = 1'b1;
        srcPkt(32'hA000_0000, 1'b1);
        expPkt(32'hA000_0000);
        driveSrc();
        drain(20);
        checkOutput("t2_locPulses", 64'(locPulses), 64'd4);
        checkOutput("t2_backToBack", 64'(lastVld - firstVld), 64'd3);
        checkOutput("t2_lastCount", 64'(lastCount), 64'd1);
        checkOutput("t2_credits", {62'b0, oCredits}, 64'd2);

        // Credit exhaustion, single return, return coinciding with a send.
        doReset();
        srcPkt(32'hB000_0000, 1'b1);
        expPkt(32'hB000_0000);
        driveSrc();
        repeat (6) step();
        checkOutput("t3_sentBeforeStall", 64'(vldCount), 64'd2);
        checkOutput("t3_creditsZero", {62'b0, oCredits}, 64'd0);
        checkOutput("t3_locLeft", 64'(locQ.size()), 64'd2);
        iCreditRet = 1'b1;
        step();
        checkOutput("t3_creditsOne", {62'b0, oCredits}, 64'd1);
        repeat (3) step();
        checkOutput("t3_oneMore", 64'(vldCount), 64'd3);
        checkOutput("t3_creditsZeroAgain", {62'b0, oCredits}, 64'd0);
        iCreditRet = 1'b1;
        step();
        iCreditRet = 1'b1;
        step();
        checkOutput("t3_retAndSend", {62'b0, oCredits}, 64'd1);
        checkOutput("t3_allSent", 64'(vldCount), 64'd4);
        iCreditRet = 1'b1;
        step();
        checkOutput("t3_creditsRestored", {62'b0, oCredits}, 64'd2);
        checkOutput("t3_sbEmpty", 64'(expQ.size()), 64'd0);

        // Starvation limit: 8 pass packets, a local, 8 more pass, the next local, then pass.
        doReset();
        autoRet = 1'b1;
        for (int k = 0; k < 17; k++) srcPkt(32'h5000_0000 + 32'(k * 16), 1'b0);
        srcPkt(32'h1000_0000, 1'b1);
        srcPkt(32'h1000_0010, 1'b1);
        for (int k = 0; k < 8; k++) expPkt(32'h5000_0000 + 32'(k * 16));
        expPkt(32'h1000_0000);
        for (int k = 8; k < 16; k++) expPkt(32'h5000_0000 + 32'(k * 16));
        expPkt(32'h1000_0010);
        expPkt(32'h5000_0100);
        driveSrc();
        drain(300);
        checkOutput("t4_locPulses", 64'(locPulses), 64'd8);
        checkOutput("t4_packets", 64'(lastCount), 64'd19);
        checkOutput("t4_credits", {62'b0, oCredits}, 64'd2);

        // Local arrives while a pass packet is at beat 2.
        doReset();
        autoRet = 1'b1;
        srcPkt(32'h3000_0000, 1'b0);
        expPkt(32'h3000_0000);
        expPkt(32'hC000_0000);
        driveSrc();
        repeat (2) step();
        srcPkt(32'hC000_0000, 1'b1);
        driveSrc();
        drain(20);

        // Reset during local beat 1 abandons the packet.
        doReset();
        autoRet = 1'b1;
        srcPkt(32'hD000_0000, 1'b1);
        expQ.push_back('{32'hD000_0000, 1'b0});
        driveSrc();
        step();
        rst = 1'b1;
        step();
        checkOutput("t6_txVld", {63'b0, oTxVld}, 64'd0);
        checkOutput("t6_credits", {62'b0, oCredits}, 64'd2);
        rst = 1'b0;
        locQ.delete();
        driveSrc();
        repeat (8) step();
        checkOutput("t6_noTail", 64'(lastCount), 64'd0);
        checkOutput("t6_sbEmpty", 64'(expQ.size()), 64'd0);
        srcPkt(32'hE000_0000, 1'b0);
        expPkt(32'hE000_0000);
        driveSrc();
        drain(20);
        checkOutput("t6_freshLast", 64'(lastCount), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
